// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath/memory side.
// Master is the controller: it reads opcode/mem_ready and drives all control strobes.
interface multicycle_control_if;
  logic [5:0]  OPcode;
  logic        mem_ready;
  logic        PC_w;
  logic        PC_w_cond;
  logic        IR_w;
  logic        Reg_w;
  logic        Mem_w;
  logic        Mem_r;
  logic        IorD;
  logic        Reg_Dst;
  logic        Mem_to_reg;
  logic        ALU_src_A;
  logic [1:0]  ALU_src_B;
  logic [1:0]  PC_src;
  logic [1:0]  ALU_OP;
  logic [3:0]  state;
  logic        instr_done;
  logic        illegal;
  logic [15:0] instr_count;

  modport master (
    input  OPcode, mem_ready,
    output PC_w, PC_w_cond, IR_w, Reg_w, Mem_w, Mem_r, IorD, Reg_Dst, Mem_to_reg,
           ALU_src_A, ALU_src_B, PC_src, ALU_OP, state, instr_done, illegal, instr_count
  );

  modport slave (
    output OPcode, mem_ready,
    input  PC_w, PC_w_cond, IR_w, Reg_w, Mem_w, Mem_r, IorD, Reg_Dst, Mem_to_reg,
           ALU_src_A, ALU_src_B, PC_src, ALU_OP, state, instr_done, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: 2-5 cycles per instruction plus one per mem_ready=0 cycle.
// Backpressure: mem_ready low stalls FETCH, MEM_READ and MEM_WRITE in place.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_EXEC_I    = 4'd8;
  localparam logic [3:0] S_I_WB      = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_ORI  = 4'b1101;
  localparam logic [3:0] OP_LW   = 4'b0011;
  localparam logic [3:0] OP_SW   = 4'b1011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0010;

  logic [3:0]  state_q, state_d, op_q;
  logic [15:0] count_q;
  logic        pc_w, pc_w_cond, ir_w, reg_w, mem_w, mem_r, iord, reg_dst, mem_to_reg;
  logic        alu_src_a, done, ill;
  logic [1:0]  alu_src_b, pc_src, alu_op;
  logic        unused_opcode_hi;

  assign unused_opcode_hi = ^bus.OPcode[5:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= 4'b0000;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        op_q <= bus.OPcode[3:0];
      if (done)
        count_q <= count_q + 16'd1;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_w       = 1'b0;
    pc_w_cond  = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    mem_r      = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = 2'b00;
    done       = 1'b0;
    ill        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_r     = 1'b1;
        alu_src_b = 2'b01;
        pc_w      = bus.mem_ready;
        ir_w      = bus.mem_ready;
        state_d   = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        alu_src_b = 2'b10;
        case (bus.OPcode[3:0])
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_R:            state_d = S_EXEC_R;
          OP_ADDI, OP_ORI: state_d = S_EXEC_I;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default:         ill     = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_r   = 1'b1;
        iord    = 1'b1;
        state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_w      = 1'b1;
        mem_to_reg = 1'b1;
        done       = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_w   = 1'b1;
        iord    = 1'b1;
        done    = bus.mem_ready;
        state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b11;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_w   = 1'b1;
        reg_dst = 1'b1;
        done    = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op_q == OP_ORI) ? 2'b10 : 2'b00;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        // ALU op stays stable so the write-back value does not glitch
        reg_w  = 1'b1;
        alu_op = (op_q == OP_ORI) ? 2'b10 : 2'b00;
        done   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_w_cond = 1'b1;
        pc_src    = 2'b01;
        done      = 1'b1;
      end
      S_JUMP: begin
        pc_w   = 1'b1;
        pc_src = 2'b10;
        done   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write strobes and pulses are gated by rst so an aborted instruction leaves nothing pending
  assign bus.PC_w        = pc_w & ~rst;
  assign bus.PC_w_cond   = pc_w_cond & ~rst;
  assign bus.IR_w        = ir_w & ~rst;
  assign bus.Reg_w       = reg_w & ~rst;
  assign bus.Mem_w       = mem_w & ~rst;
  assign bus.instr_done  = done & ~rst;
  assign bus.illegal     = ill & ~rst;
  assign bus.Mem_r       = mem_r;
  assign bus.IorD        = iord;
  assign bus.Reg_Dst     = reg_dst;
  assign bus.Mem_to_reg  = mem_to_reg;
  assign bus.ALU_src_A   = alu_src_a;
  assign bus.ALU_src_B   = alu_src_b;
  assign bus.PC_src      = pc_src;
  assign bus.ALU_OP      = alu_op;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cycle table, reset/wrap corner sequences,
// and random opcode/mem_ready traffic against a path-based instruction model.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  multicycle_control_if bus();
  multicycle_control dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [5:0]  f;      // {Reg_w, Reg_Dst, Mem_to_reg, Mem_w, PC_w, PC_w_cond}
    logic [1:0]  pcsrc;
    logic [1:0]  alu;
    logic        done;
    logic        ill;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [5:0] op, logic mr, logic [3:0] st, logic [5:0] f,
                              logic [1:0] pcsrc, logic [1:0] alu, logic done, logic ill,
                              logic [15:0] cnt);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.f = f; v.pcsrc = pcsrc; v.alu = alu;
    v.done = done; v.ill = ill; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] got_ctrl();
    return {bus.PC_w, bus.PC_w_cond, bus.IR_w, bus.Reg_w, bus.Mem_w, bus.Mem_r, bus.IorD,
            bus.Reg_Dst, bus.Mem_to_reg, bus.ALU_src_A, bus.ALU_src_B, bus.PC_src,
            bus.ALU_OP, bus.instr_done, bus.illegal};
  endfunction

  // Control word required in state s, from the per-state rules
  function automatic logic [17:0] exp_ctrl(int s, logic [3:0] lop, logic [3:0] cop, logic mr);
    logic pcw, pcwc, irw, rw, mw, mrd, iord, rd, m2r, a, done, ill;
    logic [1:0] b, pcs, alu;
    {pcw, pcwc, irw, rw, mw, mrd, iord, rd, m2r, a, done, ill} = '0;
    b = 2'b00; pcs = 2'b00; alu = 2'b00;
    case (s)
      0:  begin mrd = 1'b1; b = 2'b01; pcw = mr; irw = mr; end
      1:  begin
            b   = 2'b10;
            ill = !(cop inside {4'b0000, 4'b1001, 4'b1101, 4'b0011, 4'b1011, 4'b0100, 4'b0010});
          end
      2:  begin a = 1'b1; b = 2'b10; end
      3:  begin mrd = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
      5:  begin mw = 1'b1; iord = 1'b1; done = mr; end
      6:  begin a = 1'b1; alu = 2'b11; end
      7:  begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
      8:  begin a = 1'b1; b = 2'b10; alu = (lop == 4'b1101) ? 2'b10 : 2'b00; end
      9:  begin rw = 1'b1; alu = (lop == 4'b1101) ? 2'b10 : 2'b00; done = 1'b1; end
      10: begin a = 1'b1; alu = 2'b01; pcwc = 1'b1; pcs = 2'b01; done = 1'b1; end
      11: begin pcw = 1'b1; pcs = 2'b10; done = 1'b1; end
      default: ;
    endcase
    return {pcw, pcwc, irw, rw, mw, mrd, iord, rd, m2r, a, b, pcs, alu, done, ill};
  endfunction

  // Leaves the bench at a falling edge with rst just released and the DUT in FETCH
  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.OPcode = 6'd0;
    @(negedge clk);
    #1;
    check("reset_state", 64'(bus.state), 64'd0);
    check("reset_strobes", 64'({bus.PC_w, bus.PC_w_cond, bus.IR_w, bus.Reg_w, bus.Mem_w,
                                bus.instr_done, bus.illegal}), 64'd0);
    check("reset_count", 64'(bus.instr_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int path[$];
    int pos;
    int es;
    logic [3:0]  lop;
    logic [15:0] ecnt;
    logic [17:0] ec;

    bus.OPcode = 6'd0;
    bus.mem_ready = 1'b0;

    // R (upper opcode bits ignored), lw with 2 stalls, sw with 1 stall, beq, j, illegal, ori
    tbl.push_back(mk(6'h00, 1, 0,  6'b000010, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6'h30, 1, 1,  6'b000000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6'h00, 1, 6,  6'b000000, 0, 3, 0, 0, 0));
    tbl.push_back(mk(6'h00, 1, 7,  6'b110000, 0, 0, 1, 0, 0));
    tbl.push_back(mk(6'h03, 1, 0,  6'b000010, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h23, 1, 1,  6'b000000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h03, 1, 2,  6'b000000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h03, 0, 3,  6'b000000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h03, 0, 3,  6'b000000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h03, 1, 3,  6'b000000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h03, 1, 4,  6'b101000, 0, 0, 1, 0, 1));
    tbl.push_back(mk(6'h0B, 1, 0,  6'b000010, 0, 0, 0, 0, 2));
    tbl.push_back(mk(6'h0B, 1, 1,  6'b000000, 0, 0, 0, 0, 2));
    tbl.push_back(mk(6'h0B, 1, 2,  6'b000000, 0, 0, 0, 0, 2));
    tbl.push_back(mk(6'h0B, 0, 5,  6'b000100, 0, 0, 0, 0, 2));
    tbl.push_back(mk(6'h0B, 1, 5,  6'b000100, 0, 0, 1, 0, 2));
    tbl.push_back(mk(6'h04, 1, 0,  6'b000010, 0, 0, 0, 0, 3));
    tbl.push_back(mk(6'h04, 1, 1,  6'b000000, 0, 0, 0, 0, 3));
    tbl.push_back(mk(6'h04, 1, 10, 6'b000001, 1, 1, 1, 0, 3));
    tbl.push_back(mk(6'h02, 1, 0,  6'b000010, 0, 0, 0, 0, 4));
    tbl.push_back(mk(6'h02, 1, 1,  6'b000000, 0, 0, 0, 0, 4));
    tbl.push_back(mk(6'h02, 1, 11, 6'b000010, 2, 0, 1, 0, 4));
    tbl.push_back(mk(6'h07, 1, 0,  6'b000010, 0, 0, 0, 0, 5));
    tbl.push_back(mk(6'h07, 1, 1,  6'b000000, 0, 0, 0, 1, 5));
    tbl.push_back(mk(6'h0D, 1, 0,  6'b000010, 0, 0, 0, 0, 5));
    tbl.push_back(mk(6'h0D, 1, 1,  6'b000000, 0, 0, 0, 0, 5));
    tbl.push_back(mk(6'h0D, 1, 8,  6'b000000, 0, 2, 0, 0, 5));
    tbl.push_back(mk(6'h0D, 1, 9,  6'b100000, 0, 2, 1, 0, 5));
    tbl.push_back(mk(6'h0D, 0, 0,  6'b000000, 0, 0, 0, 0, 6));
    tbl.push_back(mk(6'h0D, 1, 0,  6'b000010, 0, 0, 0, 0, 6));

    do_reset();
    foreach (tbl[i]) begin
      bus.OPcode = tbl[i].op;
      bus.mem_ready = tbl[i].mr;
      #1;
      check($sformatf("table[%0d]", i),
            64'({bus.state, bus.Reg_w, bus.Reg_Dst, bus.Mem_to_reg, bus.Mem_w, bus.PC_w,
                 bus.PC_w_cond, bus.PC_src, bus.ALU_OP, bus.instr_done, bus.illegal,
                 bus.instr_count}),
            64'({tbl[i].st, tbl[i].f, tbl[i].pcsrc, tbl[i].alu, tbl[i].done, tbl[i].ill,
                 tbl[i].cnt}));
      @(negedge clk);
    end

    // Counter wrap: preload 0xFFFF while stalled in FETCH, then retire one jump
    do_reset();
    bus.mem_ready = 1'b0;
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    #1;
    check("wrap_preload", 64'({bus.state, bus.instr_count}), 64'({4'd0, 16'hFFFF}));
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.OPcode = 6'b000010;
    @(negedge clk);
    #1;
    check("wrap_jump", 64'({bus.state, bus.instr_done, bus.instr_count}),
          64'({4'd11, 1'b1, 16'hFFFF}));
    @(negedge clk);
    #1;
    check("wrap_count", 64'({bus.state, bus.instr_count}), 64'({4'd0, 16'h0000}));

    // Reset while stalled in MEM_WRITE aborts the store immediately
    do_reset();
    bus.OPcode = 6'b001011;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    check("sw_wait", 64'({bus.state, bus.Mem_w, bus.instr_done}), 64'({4'd5, 1'b1, 1'b0}));
    @(negedge clk);
    #1;
    check("sw_wait2", 64'({bus.state, bus.Mem_w}), 64'({4'd5, 1'b1}));
    rst = 1'b1;
    #1;
    check("abort_async", 64'({bus.state, bus.Mem_w, bus.instr_done}), 64'({4'd0, 1'b0, 1'b0}));
    bus.mem_ready = 1'b1;
    #1;
    check("abort_gated", 64'({bus.PC_w, bus.IR_w, bus.Mem_w, bus.Reg_w, bus.PC_w_cond,
                              bus.instr_done, bus.illegal, bus.Mem_r}), 64'(8'b0000_0001));
    @(negedge clk);
    #1;
    check("abort_hold", 64'({bus.state, bus.instr_count}), 64'({4'd0, 16'd0}));
    rst = 1'b0;
    #1;
    check("post_reset_fetch", 64'({bus.state, bus.PC_w, bus.IR_w}), 64'({4'd0, 1'b1, 1'b1}));

    // Random traffic: each instruction walks a fixed state path; stall states repeat
    path = '{0, 1};
    pos  = 0;
    lop  = 4'b0000;
    ecnt = 16'd0;
    for (int n = 0; n < 2000; n++) begin
      bus.OPcode = 6'($urandom);
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      es = path[pos];
      ec = exp_ctrl(es, lop, bus.OPcode[3:0], bus.mem_ready);
      check("rand_state", 64'(bus.state), 64'(es));
      check("rand_ctrl", 64'(got_ctrl()), 64'(ec));
      check("rand_count", 64'(bus.instr_count), 64'(ecnt));
      if (ec[1])
        ecnt = ecnt + 16'd1;
      if ((es == 0 || es == 3 || es == 5) && !bus.mem_ready) begin
        pos = pos;
      end else if (es == 1) begin
        lop = bus.OPcode[3:0];
        case (lop)
          4'b0000:          path = '{0, 1, 6, 7};
          4'b1001, 4'b1101: path = '{0, 1, 8, 9};
          4'b0011:          path = '{0, 1, 2, 3, 4};
          4'b1011:          path = '{0, 1, 2, 5};
          4'b0100:          path = '{0, 1, 10};
          4'b0010:          path = '{0, 1, 11};
          default:          path = '{0, 1};
        endcase
        pos = 2;
        if (pos >= path.size()) pos = 0;
      end else begin
        pos++;
        if (pos >= path.size()) begin
          path = '{0, 1};
          pos  = 0;
        end
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, single clock; all state updates on the rising edge.
REQ-002 rst, input, 1, asynchronous, active-high reset.
REQ-003 OPcode, input, 6, instruction opcode from the IR; only OPcode[3:0] is decoded.
REQ-004 mem_ready, input, 1, memory access completes in this cycle.
REQ-005 PC_w, PC_w_cond, IR_w, Reg_w, Mem_w, Mem_r, output, 1 each: PC write, conditional PC write (datapath ANDs it with ALU zero), IR write, register-file write, memory write, memory read.
REQ-006 IorD, Reg_Dst, Mem_to_reg, ALU_src_A, output, 1 each, datapath mux selects.
REQ-007 ALU_src_B, output, 2: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate.
REQ-008 PC_src, output, 2: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
REQ-009 ALU_OP, output, 2: 00 = add, 01 = sub, 10 = or, 11 = decode from funct.
REQ-010 state, output, 4, current state code.
REQ-011 instr_done, illegal, output, 1 each, one-cycle pulses.
REQ-012 instr_count, output, 16, count of retired instructions.

Function
REQ-013 Opcode map on OPcode[3:0]: 0000 R-type, 1001 addi, 1101 ori, 0011 lw, 1011 sw, 0100 beq, 0010 j; all other values are illegal.
REQ-014 States and codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, R_WB 7, EXEC_I 8, I_WB 9, BRANCH 10, JUMP 11; codes 12-15 are unreachable and SHALL return to FETCH on the next clock.
REQ-015 FETCH: Mem_r=1, IorD=0, ALU_src_A=0, ALU_src_B=01, ALU_OP=00, PC_src=00; IR_w=PC_w=mem_ready; the block stays in FETCH while mem_ready=0 and moves to DECODE when mem_ready=1.
REQ-016 DECODE: ALU_src_A=0, ALU_src_B=10, ALU_OP=00 (branch target precompute); OPcode[3:0] is latched into an internal op register.
REQ-017 DECODE next state: lw/sw -> MEM_ADDR, R -> EXEC_R, addi/ori -> EXEC_I, beq -> BRANCH, j -> JUMP, illegal -> FETCH with illegal=1 for that cycle.
REQ-018 MEM_ADDR: ALU_src_A=1, ALU_src_B=10, ALU_OP=00; next state is MEM_READ for lw and MEM_WRITE for sw.
REQ-019 MEM_READ: Mem_r=1, IorD=1; the block waits for mem_ready=1, then moves to MEM_WB.
REQ-020 MEM_WB: Reg_w=1, Reg_Dst=0, Mem_to_reg=1; next state FETCH.
REQ-021 MEM_WRITE: Mem_w=1, IorD=1; the block holds Mem_w=1 until mem_ready=1, then moves to FETCH.
REQ-022 EXEC_R: ALU_src_A=1, ALU_src_B=00, ALU_OP=11; next state R_WB.
REQ-023 R_WB: Reg_w=1, Reg_Dst=1, Mem_to_reg=0; next state FETCH.
REQ-024 EXEC_I: ALU_src_A=1, ALU_src_B=10; ALU_OP=00 for addi and 10 for ori (from the latched op); next state I_WB.
REQ-025 I_WB: Reg_w=1, Reg_Dst=0, Mem_to_reg=0, ALU_OP held as in EXEC_I; next state FETCH.
REQ-026 BRANCH: ALU_src_A=1, ALU_src_B=00, ALU_OP=01, PC_w_cond=1, PC_src=01; next state FETCH.
REQ-027 JUMP: PC_w=1, PC_src=10; next state FETCH.
REQ-028 Any output not listed for a state SHALL be 0; every output SHALL be a pure function of state, latched op and mem_ready.
REQ-029 Latency with mem_ready=1: beq and j take 3 cycles; R, addi, ori and sw take 4; lw takes 5; illegal takes 2. Each mem_ready=0 cycle adds one cycle in FETCH, MEM_READ or MEM_WRITE.
REQ-030 instr_done SHALL equal 1 in MEM_WB, R_WB, I_WB, BRANCH and JUMP, and in MEM_WRITE when mem_ready=1; it is never asserted for an illegal opcode.
REQ-031 instr_count SHALL increment by 1 on each clock edge where instr_done=1, wrapping from 0xFFFF to 0x0000.

Reset
REQ-032 While rst=1: state=FETCH, latched op=0000, instr_count=0, and PC_w, PC_w_cond, IR_w, Reg_w, Mem_w, instr_done and illegal are forced to 0 regardless of mem_ready.
REQ-033 Assertion of rst in any state, including mid-wait in MEM_WRITE, SHALL abort the instruction immediately without a pending write; after deassertion the first rising edge evaluates FETCH.

Verification
REQ-034 rst=1, then rst=0 with mem_ready=1 and OPcode=000000 -> state sequence 0,1,6,7,0; Reg_w=1 and Reg_Dst=1 only in state 7; instr_count=1.
REQ-035 OPcode=000011 (lw) with mem_ready=0 for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0; Mem_to_reg=1 and Reg_w=1 in state 4 only.
REQ-036 OPcode=001011 (sw) with mem_ready low 1 cycle -> Mem_w=1 for exactly 2 cycles in state 5; instr_done pulses on the second of them; Reg_w stays 0 throughout.
REQ-037 OPcode=000100 (beq) then 000010 (j) -> BRANCH shows PC_w_cond=1, PC_src=01, ALU_OP=01; JUMP shows PC_w=1, PC_src=10; each instruction takes 3 cycles.
REQ-038 OPcode=000111 (illegal) -> states 0,1,0; illegal=1 in the DECODE cycle; instr_count unchanged.
REQ-039 Preload instr_count to 0xFFFF via 65535 j instructions, then one more -> instr_count=0x0000; separately, rst asserted mid-MEM_WRITE -> Mem_w drops to 0 asynchronously and state=0.
